// File: rtl/uart_tx_datapath.sv
// uart_tx_datapath: UART transmit datapath (shift register, bit counter,
// parity, line mux). It sits below the transmit control FSM and the TX FIFO.
//
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   tx_tick        - one-cycle baud strobe
//   shift_load     - 1: shift on tx_tick, 0: hold/load
//   syn_clr        - 0: clear bit counter, 1: count on tx_tick
//   tx_done        - high throughout START; its rising edge loads a frame
//   tx_control     - line select: 00 start, 01 data, 10 parity, 11 idle/stop
//   tx_data        - TX FIFO head word
//   WLS            - word length select (DATA_W-3 .. DATA_W)
//   EPS            - 1 even parity, 0 odd parity
//   SP             - stick parity (only with UART_TX_STICK_PARITY_EN)
//   fifo_rd        - one-cycle FIFO pop, combinational from the load detect
//   data_done      - last data bit on the line, combinational from registers
//   tx_out         - registered serial line
//
// Optional feature macro: UART_TX_STICK_PARITY_EN adds the SP input.
module uart_tx_datapath #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_tick,
    input  logic              shift_load,
    input  logic              syn_clr,
    input  logic              tx_done,
    input  logic [1:0]        tx_control,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [1:0]        WLS,
    input  logic              EPS,
`ifdef UART_TX_STICK_PARITY_EN
    input  logic              SP,
`endif
    output logic              fifo_rd,
    output logic              data_done,
    output logic              tx_out
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned LEN_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        LINE_START = 2'b00,
        LINE_DATA  = 2'b01,
        LINE_PAR   = 2'b10,
        LINE_IDLE  = 2'b11
    } line_sel_e;

    logic [DATA_W-1:0] shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        wl_q, wl_d;
    logic              par_q, par_d;
    logic              tx_done_prev_q, tx_done_prev_d;   // previous-cycle tx_done
    logic              tx_out_q, tx_out_d;

    logic              load_c;
    logic [LEN_W-1:0]  wls_len_c;
    logic [DATA_W-1:0] masked_c;
    logic              par_calc_c;

    // Word length in bits for a given select code.
    function automatic logic [LEN_W-1:0] word_len(input logic [1:0] wl);
        return LEN_W'(DATA_W - 3) + LEN_W'(wl);
    endfunction

    // Next-state logic for all datapath registers plus the two strobes.
    always_comb begin
        shift_reg_d    = shift_reg_q;
        cnt_d          = cnt_q;
        wl_d           = wl_q;
        par_d          = par_q;
        tx_done_prev_d = tx_done;
        tx_out_d       = 1'b1;
        masked_c       = '0;

        load_c    = tx_done & ~tx_done_prev_q;
        wls_len_c = word_len(WLS);

        // Clear bits at or above the selected word length.
        for (int i = 0; i < int'(DATA_W); i++) begin
            masked_c[i] = tx_data[i] & (LEN_W'(i) < wls_len_c);
        end

        par_calc_c = EPS ? (^masked_c) : (~^masked_c);
`ifdef UART_TX_STICK_PARITY_EN
        if (SP) begin
            par_calc_c = ~EPS;
        end
`endif

        // Load has priority over a shift should both ever be requested.
        if (load_c) begin
            shift_reg_d = masked_c;
            wl_d        = WLS;
            par_d       = par_calc_c;
        end else if (shift_load && tx_tick) begin
            shift_reg_d = {1'b0, shift_reg_q[DATA_W-1:1]};
        end

        if (!syn_clr) begin
            cnt_d = '0;
        end else if (tx_tick && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (line_sel_e'(tx_control))
            LINE_START: tx_out_d = 1'b0;
            LINE_DATA:  tx_out_d = shift_reg_q[0];
            LINE_PAR:   tx_out_d = par_q;
            default:    tx_out_d = 1'b1;
        endcase

        // Suppressed while in reset so a held tx_done pops nothing.
        fifo_rd   = load_c & ~rst;
        data_done = syn_clr & (LEN_W'(cnt_q) == (word_len(wl_q) - LEN_W'(1)));
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg_q    <= '0;
            cnt_q          <= '0;
            wl_q           <= 2'b11;
            par_q          <= 1'b0;
            tx_done_prev_q <= 1'b0;
            tx_out_q       <= 1'b1;
        end else begin
            shift_reg_q    <= shift_reg_d;
            cnt_q          <= cnt_d;
            wl_q           <= wl_d;
            par_q          <= par_d;
            tx_done_prev_q <= tx_done_prev_d;
            tx_out_q       <= tx_out_d;
        end
    end

    assign tx_out = tx_out_q;

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Self-checking bench for uart_tx_datapath: the bench plays the control FSM,
// drives whole frames and compares the line against a frame-level model.
module tb_uart_tx_datapath;

    localparam int DW  = 8;
    localparam int MAXB = 16;

    logic          clk = 1'b0;
    logic          rst, tx_tick, shift_load, syn_clr, tx_done, EPS;
    logic [1:0]    tx_control, WLS;
    logic [DW-1:0] tx_data;
`ifdef UART_TX_STICK_PARITY_EN
    logic          SP;
`endif
    logic          fifo_rd, data_done, tx_out;

    int checks = 0;
    int errors = 0;

    logic obs_out [MAXB];
    logic obs_dd  [MAXB];
    logic exp_out [MAXB];
    logic exp_dd  [MAXB];
    int   n_obs, n_exp;
    logic rd_first_g;
    int   rd_total_g;

    uart_tx_datapath #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_tick    (tx_tick),
        .shift_load (shift_load),
        .syn_clr    (syn_clr),
        .tx_done    (tx_done),
        .tx_control (tx_control),
        .tx_data    (tx_data),
        .WLS        (WLS),
        .EPS        (EPS),
`ifdef UART_TX_STICK_PARITY_EN
        .SP         (SP),
`endif
        .fifo_rd    (fifo_rd),
        .data_done  (data_done),
        .tx_out     (tx_out)
    );

    always #5 clk = ~clk;

    // One bit period of four clocks, tx_tick on the last; samples mid-period.
    task automatic drive_period(input logic [1:0] ctl, input logic sh, input logic clr,
                                input logic dn, output logic s_out, output logic s_dd,
                                output logic rd_first, output int rd_n);
        rd_n = 0;
        rd_first = 1'b0;
        s_out = 1'bx;
        s_dd = 1'bx;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tx_control = ctl; shift_load = sh; syn_clr = clr; tx_done = dn;
            tx_tick = (i == 3);
            @(negedge clk);
            if (i == 0) rd_first = fifo_rd;
            if (i == 2) begin s_out = tx_out; s_dd = data_done; end
            if (fifo_rd === 1'b1) rd_n++;
        end
    endtask

    // Plays one frame as the FSM would; optionally disturbs WLS/EPS/tx_data mid-DATA.
    task automatic run_frame(input logic [DW-1:0] data, input logic [1:0] wls, input logic eps,
                             input logic sp, input bit par_en, input bit chg);
        logic o, d, rf;
        int rn, len;
        len = DW - 3 + int'(wls);
        tx_data = data; WLS = wls; EPS = eps;
`ifdef UART_TX_STICK_PARITY_EN
        SP = sp;
`endif
        n_obs = 0; rd_total_g = 0;
        drive_period(2'b00, 1'b0, 1'b0, 1'b1, o, d, rf, rn);
        rd_first_g = rf; rd_total_g += rn;
        obs_out[n_obs] = o; obs_dd[n_obs] = d; n_obs++;
        for (int k = 0; k < len; k++) begin
            if (chg && k == 2) begin
                WLS = ~wls; EPS = ~eps; tx_data = DW'($urandom);
`ifdef UART_TX_STICK_PARITY_EN
                SP = ~sp;
`endif
            end
            drive_period(2'b01, 1'b1, 1'b1, 1'b0, o, d, rf, rn);
            rd_total_g += rn;
            obs_out[n_obs] = o; obs_dd[n_obs] = d; n_obs++;
        end
        if (par_en) begin
            drive_period(2'b10, 1'b0, 1'b0, 1'b0, o, d, rf, rn);
            rd_total_g += rn;
            obs_out[n_obs] = o; obs_dd[n_obs] = d; n_obs++;
        end
        drive_period(2'b11, 1'b0, 1'b0, 1'b0, o, d, rf, rn);
        rd_total_g += rn;
        obs_out[n_obs] = o; obs_dd[n_obs] = d; n_obs++;
    endtask

    // Frame model: start 0, masked word LSB first, parity, stop 1.
    task automatic build_expected(input logic [DW-1:0] data, input logic [1:0] wls,
                                  input logic eps, input logic sp, input bit par_en);
        int len, m, ones, par;
        len = DW - 3 + int'(wls);
        m = int'(data) % (1 << len);
        ones = 0;
        n_exp = 0;
        exp_out[n_exp] = 1'b0; exp_dd[n_exp] = 1'b0; n_exp++;
        for (int k = 0; k < len; k++) begin
            exp_out[n_exp] = 1'((m >> k) % 2);
            exp_dd[n_exp]  = (k == len - 1);
            ones += (m >> k) % 2;
            n_exp++;
        end
        if (sp) par = eps ? 0 : 1;
        else    par = eps ? (ones % 2) : (1 - ones % 2);
        if (par_en) begin
            exp_out[n_exp] = 1'(par); exp_dd[n_exp] = 1'b0; n_exp++;
        end
        exp_out[n_exp] = 1'b1; exp_dd[n_exp] = 1'b0; n_exp++;
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_done = 1'b1; tx_control = 2'b00; syn_clr = 1'b1;
        shift_load = 1'b1; tx_tick = 1'b0; tx_data = DW'($urandom); WLS = 2'b00; EPS = 1'b0;
`ifdef UART_TX_STICK_PARITY_EN
        SP = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1) begin errors++; $display("FAIL reset tx_out got %b want 1", tx_out); end
        checks++;
        if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset fifo_rd got %b want 0", fifo_rd); end
        checks++;
        if (data_done !== 1'b0) begin errors++; $display("FAIL reset data_done got %b want 0", data_done); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_rd !== 1'b1) begin errors++; $display("FAIL post_reset_load fifo_rd got %b want 1", fifo_rd); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (fifo_rd !== 1'b0) begin errors++; $display("FAIL post_reset_single fifo_rd got %b want 0", fifo_rd); end
        @(posedge clk); #1;
        tx_done = 1'b0; syn_clr = 1'b0; shift_load = 1'b0; tx_control = 2'b11;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_directed();
        logic [DW-1:0] d_tab [4] = '{8'hA5, 8'hFF, 8'h55, 8'hC3};
        logic [1:0]    w_tab [4] = '{2'b11, 2'b00, 2'b10, 2'b11};
        logic          e_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        bit            p_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        bit            c_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 4; t++) begin
            build_expected(d_tab[t], w_tab[t], e_tab[t], 1'b0, p_tab[t]);
            run_frame(d_tab[t], w_tab[t], e_tab[t], 1'b0, p_tab[t], c_tab[t]);
            checks++;
            if (n_obs != n_exp) begin errors++; $display("FAIL directed%0d length got %0d want %0d", t, n_obs, n_exp); end
            for (int i = 0; i < n_exp; i++) begin
                checks++;
                if (obs_out[i] !== exp_out[i]) begin
                    errors++; $display("FAIL directed%0d tx_out bit %0d got %b want %b", t, i, obs_out[i], exp_out[i]);
                end
                checks++;
                if (obs_dd[i] !== exp_dd[i]) begin
                    errors++; $display("FAIL directed%0d data_done bit %0d got %b want %b", t, i, obs_dd[i], exp_dd[i]);
                end
            end
            checks++;
            if (rd_first_g !== 1'b1 || rd_total_g != 1) begin
                errors++; $display("FAIL directed%0d fifo_rd first %b count %0d want 1/1", t, rd_first_g, rd_total_g);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic [1:0] w;
        logic e;
        bit p;
        for (int t = 0; t < 10; t++) begin
            d = DW'($urandom); w = 2'($urandom_range(0, 3)); e = 1'($urandom_range(0, 1));
            p = 1'($urandom_range(0, 1));
            build_expected(d, w, e, 1'b0, p);
            run_frame(d, w, e, 1'b0, p, 1'b0);
            for (int i = 0; i < n_exp; i++) begin
                checks++;
                if (obs_out[i] !== exp_out[i] || obs_dd[i] !== exp_dd[i]) begin
                    errors++;
                    $display("FAIL b2b%0d bit %0d tx_out/data_done got %b/%b want %b/%b (data %h wls %b eps %b)",
                             t, i, obs_out[i], obs_dd[i], exp_out[i], exp_dd[i], d, w, e);
                end
            end
            checks++;
            if (rd_first_g !== 1'b1 || rd_total_g != 1) begin
                errors++; $display("FAIL b2b%0d fifo_rd first %b count %0d want 1/1", t, rd_first_g, rd_total_g);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic o, d, rf;
        int rn, rd_sum;
        tx_data = DW'($urandom); WLS = 2'b11; EPS = 1'b1;
        drive_period(2'b00, 1'b0, 1'b0, 1'b1, o, d, rf, rn);
        for (int k = 0; k < 3; k++) drive_period(2'b01, 1'b1, 1'b1, 1'b0, o, d, rf, rn);
        @(posedge clk); #1;
        tx_control = 2'b01; shift_load = 1'b1; syn_clr = 1'b1; tx_done = 1'b0; tx_tick = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1) begin errors++; $display("FAIL rst_mid tx_out got %b want 1", tx_out); end
        checks++;
        if (data_done !== 1'b0) begin errors++; $display("FAIL rst_mid data_done got %b want 0", data_done); end
        checks++;
        if (dut.cnt_q !== 3'd0) begin errors++; $display("FAIL rst_mid cnt got %0d want 0", dut.cnt_q); end
        checks++;
        if (fifo_rd !== 1'b0) begin errors++; $display("FAIL rst_mid fifo_rd got %b want 0", fifo_rd); end
        rd_sum = 0;
        for (int k = 0; k < 2; k++) begin
            drive_period(2'b11, 1'b0, 1'b0, 1'b0, o, d, rf, rn);
            rd_sum += rn;
            checks++;
            if (o !== 1'b1) begin errors++; $display("FAIL rst_mid idle tx_out got %b want 1", o); end
        end
        checks++;
        if (rd_sum != 0) begin errors++; $display("FAIL rst_mid extra fifo_rd got %0d want 0", rd_sum); end
        // A clean frame afterwards must still be correct.
        build_expected(8'h3C, 2'b11, 1'b0, 1'b0, 1'b1);
        run_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < n_exp; i++) begin
            checks++;
            if (obs_out[i] !== exp_out[i]) begin
                errors++; $display("FAIL rst_mid recovery bit %0d got %b want %b", i, obs_out[i], exp_out[i]);
            end
        end
    endtask

`ifdef UART_TX_STICK_PARITY_EN
    task automatic test_stick_parity();
        logic [DW-1:0] d;
        logic e;
        for (int t = 0; t < 4; t++) begin
            d = DW'($urandom); e = 1'(t % 2);
            build_expected(d, 2'b11, e, 1'b1, 1'b1);
            run_frame(d, 2'b11, e, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_out[n_exp-2] !== exp_out[n_exp-2]) begin
                errors++; $display("FAIL stick%0d parity got %b want %b (eps %b)", t, obs_out[n_exp-2], exp_out[n_exp-2], e);
            end
            for (int i = 0; i < n_exp; i++) begin
                checks++;
                if (obs_out[i] !== exp_out[i]) begin
                    errors++; $display("FAIL stick%0d bit %0d got %b want %b", t, i, obs_out[i], exp_out[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_TX_STICK_PARITY_EN
        test_stick_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
